// File: rtl/word_accumulator_pkg.sv
// Shared types and default sizing for the word accumulator stage.
// Width helpers keep the package defaults and module parameters consistent.
package word_accumulator_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_COUNT      = 4;

    function automatic int sum_width(input int data_width, input int count);
        return data_width + $clog2(count);
    endfunction

    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

    localparam int DEF_SUM_W = sum_width(DEF_DATA_WIDTH, DEF_COUNT);
    localparam int DEF_CNT_W = cnt_width(DEF_COUNT);

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

endpackage

// File: rtl/word_accumulator_add_core.sv
// Combinational ripple-carry adder: a chain of one-bit full-adder cells.
module acc_add_core
    import word_accumulator_pkg::*;
#(
    parameter int W = DEF_SUM_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic half;
        assign half       = a[i] ^ b[i];
        assign s[i]       = half ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & half);
    end

    assign co = carry[W];

endmodule

// File: rtl/word_accumulator.sv
// Burst accumulator: sums up to COUNT words (or until in_last) and emits
// one widened sum plus word count per burst over a vld/rd handshake.
module word_accumulator
    import word_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COUNT      = DEF_COUNT,
    parameter int SUM_W      = sum_width(DATA_WIDTH, COUNT),
    parameter int CNT_W      = cnt_width(COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_vld,
    output logic                  in_rd,
    output logic [SUM_W-1:0]      out_sum,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  out_vld,
    input  logic                  out_rd
);

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] in_ext;
    logic [SUM_W-1:0] sum;
    logic             add_co_unused;
    logic             xfer;
    logic             close;
    logic [CNT_W-1:0] cnt_next;

    assign in_ext   = {{(SUM_W-DATA_WIDTH){1'b0}}, in_data};
    assign xfer     = in_vld && in_rd;
    assign close    = in_last || (cnt == CNT_W'(COUNT - 1));
    assign cnt_next = cnt + 1'b1;

    // Carry-out is always 0: COUNT*(2^DATA_WIDTH-1) fits in SUM_W bits.
    acc_add_core #(
        .W(SUM_W)
    ) u_add (
        .a (acc),
        .b (in_ext),
        .ci(1'b0),
        .s (sum),
        .co(add_co_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
            in_rd   <= 1'b1;
            out_vld <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        if (close) begin
                            out_sum <= sum;
                            out_cnt <= cnt_next;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= OUTPUT;
                            in_rd   <= 1'b0;
                            out_vld <= 1'b1;
                        end else begin
                            acc <= sum;
                            cnt <= cnt_next;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_rd) begin
                        state   <= ACCUM;
                        in_rd   <= 1'b1;
                        out_vld <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_accumulator.sv
// Directed and randomized checks for word_accumulator (DATA_WIDTH=4, COUNT=4).
module tb_word_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_rd;
    logic [5:0] out_sum;
    logic [2:0] out_cnt;
    logic       out_vld;
    logic       out_rd = 1'b1;

    int checks = 0;
    int passes = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    word_accumulator #(
        .DATA_WIDTH(4),
        .COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_last(in_last),
        .in_vld(in_vld),
        .in_rd(in_rd),
        .out_sum(out_sum),
        .out_cnt(out_cnt),
        .out_vld(out_vld),
        .out_rd(out_rd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until an edge sees in_rd=1; returns #1 after that edge.
    task automatic send_word(input logic [3:0] d, input logic l);
        logic rdy;
        int n;
        in_data = d;
        in_last = l;
        in_vld  = 1'b1;
        n = 0;
        do begin
            rdy = in_rd;
            step();
            n++;
        end while (!rdy && n < 50);
        in_vld  = 1'b0;
        in_last = 1'b0;
        if (!rdy) begin
            checks++;
            $display("FAIL send_word_timeout: in_rd stayed 0, required 1 within 50 cycles");
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({in_rd, out_vld, out_sum, out_cnt} !== {1'b1, 1'b0, 6'd0, 3'd0})
            $display("FAIL reset_values: rd=%0b vld=%0b sum=%0d cnt=%0d, required 1 0 0 0",
                     in_rd, out_vld, out_sum, out_cnt);
        else passes++;
        rst = 1'b0;
        step();
        send_word(4'd2, 1'b1);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd2, 3'd1})
            $display("FAIL pre_reset_burst: vld=%0b sum=%0d cnt=%0d, required 1 2 1",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
        send_word(4'd3, 1'b0);
        send_word(4'd5, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_vld, in_rd, out_sum, out_cnt} !== {1'b0, 1'b1, 6'd0, 3'd0})
            $display("FAIL reset_mid_burst: vld=%0b rd=%0b sum=%0d cnt=%0d, required 0 1 0 0",
                     out_vld, in_rd, out_sum, out_cnt);
        else passes++;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({in_rd, out_vld} !== 2'b10)
            $display("FAIL after_reset_release: rd=%0b vld=%0b, required 1 0", in_rd, out_vld);
        else passes++;
        for (int i = 0; i < 4; i++) send_word(4'd1, 1'b0);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd4, 3'd4})
            $display("FAIL reset_discard: vld=%0b sum=%0d cnt=%0d, required 1 4 4",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
    endtask

    task automatic test_full_burst();
        out_rd = 1'b1;
        for (int i = 0; i < 4; i++) send_word(4'd15, 1'b0);
        checks++;
        if ({out_vld, in_rd, out_sum, out_cnt} !== {1'b1, 1'b0, 6'd60, 3'd4})
            $display("FAIL full_burst: vld=%0b rd=%0b sum=%0d cnt=%0d, required 1 0 60 4",
                     out_vld, in_rd, out_sum, out_cnt);
        else passes++;
        step();
        checks++;
        if ({out_vld, in_rd} !== 2'b01)
            $display("FAIL full_burst_one_cycle: vld=%0b rd=%0b, required 0 1", out_vld, in_rd);
        else passes++;
    endtask

    task automatic test_early_term();
        send_word(4'd7, 1'b0);
        send_word(4'd2, 1'b1);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd9, 3'd2})
            $display("FAIL early_term: vld=%0b sum=%0d cnt=%0d, required 1 9 2",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
        send_word(4'd6, 1'b1);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd6, 3'd1})
            $display("FAIL single_word: vld=%0b sum=%0d cnt=%0d, required 1 6 1",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
    endtask

    task automatic test_back_pressure();
        out_rd = 1'b0;
        send_word(4'd1, 1'b0);
        send_word(4'd2, 1'b0);
        send_word(4'd3, 1'b0);
        send_word(4'd4, 1'b0);
        in_data = 4'd9;
        in_last = 1'b1;
        in_vld  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_vld, in_rd, out_sum, out_cnt} !== {1'b1, 1'b0, 6'd10, 3'd4})
                $display("FAIL stall_hold[%0d]: vld=%0b rd=%0b sum=%0d cnt=%0d, required 1 0 10 4",
                         k, out_vld, in_rd, out_sum, out_cnt);
            else passes++;
            step();
        end
        out_rd = 1'b1;
        step();
        checks++;
        if ({out_vld, in_rd, out_sum} !== {1'b0, 1'b1, 6'd10})
            $display("FAIL stall_release: vld=%0b rd=%0b sum=%0d, required 0 1 10",
                     out_vld, in_rd, out_sum);
        else passes++;
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd9, 3'd1})
            $display("FAIL post_stall_word: vld=%0b sum=%0d cnt=%0d, required 1 9 1",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
    endtask

    task automatic test_gaps();
        send_word(4'd8, 1'b0);
        in_data = 4'hF;
        in_last = 1'b1;
        repeat (3) step();
        send_word(4'd4, 1'b0);
        in_data = 4'hA;
        in_last = 1'b1;
        step();
        send_word(4'd2, 1'b0);
        send_word(4'd1, 1'b0);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd15, 3'd4})
            $display("FAIL input_gaps: vld=%0b sum=%0d cnt=%0d, required 1 15 4",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
    endtask

    task automatic test_last_on_count();
        send_word(4'd1, 1'b0);
        send_word(4'd2, 1'b0);
        send_word(4'd3, 1'b0);
        send_word(4'd4, 1'b1);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd10, 3'd4})
            $display("FAIL last_on_count: vld=%0b sum=%0d cnt=%0d, required 1 10 4",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
        send_word(4'd5, 1'b1);
        checks++;
        if ({out_vld, out_sum, out_cnt} !== {1'b1, 6'd5, 3'd1})
            $display("FAIL after_last_on_count: vld=%0b sum=%0d cnt=%0d, required 1 5 1",
                     out_vld, out_sum, out_cnt);
        else passes++;
        step();
    endtask

    task automatic soak_driver(input int nbursts);
        for (int b = 0; b < nbursts; b++) begin
            int len;
            int sum;
            logic [3:0] w[4];
            logic last_on_final;
            len = $urandom_range(1, 4);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                w[i] = 4'($urandom_range(0, 15));
                sum += w[i];
            end
            last_on_final = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_q.push_back({6'(sum), 3'(len)});
            for (int i = 0; i < len; i++) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    in_vld  = 1'b0;
                    in_data = 4'($urandom);
                    in_last = 1'($urandom);
                    step();
                end
                send_word(w[i], (i == len - 1) ? last_on_final : 1'b0);
            end
        end
    endtask

    task automatic soak_monitor(input int nbursts);
        int got;
        int cyc;
        logic [8:0] exp;
        got = 0;
        cyc = 0;
        while (got < nbursts && cyc < 60000) begin
            out_rd = ($urandom_range(0, 3) != 0);
            if (out_vld && out_rd) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL soak_unexpected: sum=%0d cnt=%0d with no burst outstanding",
                             out_sum, out_cnt);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_sum, out_cnt} !== exp)
                        $display("FAIL soak_burst[%0d]: sum=%0d cnt=%0d, required %0d %0d",
                                 got, out_sum, out_cnt, exp[8:3], exp[2:0]);
                    else passes++;
                end
                got++;
            end
            step();
            cyc++;
        end
        out_rd = 1'b1;
        if (got < nbursts) begin
            checks++;
            $display("FAIL soak_timeout: received %0d bursts, required %0d", got, nbursts);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_early_term();
        test_back_pressure();
        test_gaps();
        test_last_on_count();
        fork
            soak_driver(1000);
            soak_monitor(1000);
        join
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
